gate_truth_checker: RTL and testbench

Self-test sequencer for two-input gate modules such as `or_gate`. It sits on both sides of the gate under test: it drives the gate's two inputs through all four input combinations and consumes the gate's output. Each sample is compared against a parameterised expected truth table, and the block reports pass/fail, an error count and a per-vector failure mask. It is used on the board top and in benches to check any gate in the gates collection.

---
 rtl/gates_pkg.sv | 18 +
 rtl/gate_truth_checker.sv | 87 ++++++++
 tb/tb_gate_truth_checker.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/gates_pkg.sv
// Shared definitions for the two-input gate collection and its self-test checker.
package gates_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Truth tables are indexed by {a,b}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_truth_checker.sv
// Sweeps a two-input gate through all four vectors and compares against EXPECT; done at 4*(SETTLE_CYCLES+1)+1 cycles after start.
// No backpressure: start is a level request honoured only in IDLE, ignored (not queued) while busy or done.
module gate_truth_checker
  import gates_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECT        = TT_OR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);

  state_t           state;
  logic [1:0]       vec;
  logic [CNT_W-1:0] cnt;
  logic             sample;
  logic             miss;

  assign sample = (state == ST_SETTLE) && (cnt == '0);
  assign miss   = sample && (dut_c != EXPECT[vec]);
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec       <= 2'd0;
      cnt       <= '0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_mask <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_SETTLE;
            vec            <= 2'd0;
            cnt            <= CNT_LOAD;
            err_count      <= 3'd0;
            fail_mask      <= 4'd0;
            pass           <= 1'b0;
            {dut_a, dut_b} <= 2'b00;
          end
        end
        ST_SETTLE: begin
          if (miss) begin
            err_count      <= err_count + 3'd1;
            fail_mask[vec] <= 1'b1;
          end
          if (!sample) begin
            cnt <= cnt - CNT_W'(1);
          end else if (vec != 2'd3) begin
            vec            <= vec + 2'd1;
            cnt            <= CNT_LOAD;
            {dut_a, dut_b} <= vec + 2'd1;
          end else begin
            // Fold in the final sample so pass is valid alongside done.
            state <= ST_DONE;
            done  <= 1'b1;
            pass  <= (err_count == 3'd0) && !miss;
          end
        end
        ST_DONE: begin
          state          <= ST_IDLE;
          {dut_a, dut_b} <= 2'b00;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three checker instances with different settle/expect settings,
// each wired to a gate whose truth table the bench chooses at run time.
module tb_gate_truth_checker;
  import gates_pkg::*;

  localparam int         SC     [3] = '{2, 0, 3};
  localparam logic [3:0] EXP_TT [3] = '{TT_OR, TT_OR, TT_AND};

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic [2:0] a_v, b_v, c_v, busy_v, done_v, pass_v;
  logic [2:0] err_v  [3];
  logic [3:0] mask_v [3];
  logic [3:0] gtt    [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = clk_en ? ~clk : 1'b0;

  // Gates under test: arbitrary combinational truth tables.
  assign c_v[0] = gtt[0][{a_v[0], b_v[0]}];
  assign c_v[1] = gtt[1][{a_v[1], b_v[1]}];
  assign c_v[2] = gtt[2][{a_v[2], b_v[2]}];

  gate_truth_checker #(.SETTLE_CYCLES(2), .EXPECT(TT_OR)) u_chk0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_a(a_v[0]), .dut_b(b_v[0]),
    .dut_c(c_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err_v[0]), .fail_mask(mask_v[0]));

  gate_truth_checker #(.SETTLE_CYCLES(0), .EXPECT(TT_OR)) u_chk1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_a(a_v[1]), .dut_b(b_v[1]),
    .dut_c(c_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err_v[1]), .fail_mask(mask_v[1]));

  gate_truth_checker #(.SETTLE_CYCLES(3), .EXPECT(TT_AND)) u_chk2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_a(a_v[2]), .dut_b(b_v[2]),
    .dut_c(c_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(err_v[2]), .fail_mask(mask_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int idx, input string tag);
    check(tag, {20'd0, a_v[idx], b_v[idx], busy_v[idx], done_v[idx], pass_v[idx],
                err_v[idx], mask_v[idx]}, 32'd0);
  endtask

  // One sweep on instance idx; expected results come from XOR against the expected table.
  // poke>0 re-asserts start for one edge in cycle poke of the sweep.
  task automatic sweep(input int idx, input logic [3:0] gate, input int poke, input string tag);
    int s, k, bad, e;
    logic [3:0] m;
    s = SC[idx];
    gtt[idx] = gate;
    m = gate ^ EXP_TT[idx];
    e = $countones(m);
    start_v[idx] = 1'b1;
    step();
    start_v[idx] = 1'b0;
    k = 1;
    bad = 0;
    while (!done_v[idx] && k < 300) begin
      if ({a_v[idx], b_v[idx]} !== 2'((k - 1) / (s + 1)) || busy_v[idx] !== 1'b1) bad++;
      start_v[idx] = (k == poke);
      step();
      k++;
    end
    start_v[idx] = 1'b0;
    check({tag, "_latency"}, k, 4 * (s + 1) + 1);
    check({tag, "_vectors"}, bad, 0);
    check({tag, "_pass"}, pass_v[idx], (e == 0));
    check({tag, "_err_count"}, err_v[idx], e);
    check({tag, "_fail_mask"}, mask_v[idx], m);
    check({tag, "_busy_in_done"}, busy_v[idx], 1);
    step();
    check({tag, "_after_done"}, {done_v[idx], busy_v[idx], a_v[idx], b_v[idx]}, 0);
    check({tag, "_held"}, {pass_v[idx], err_v[idx], mask_v[idx]}, {(e == 0), 3'(e), m});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int k, ndone, first, prev, bad;
    gtt[0] = TT_OR;
    gtt[1] = TT_OR;
    gtt[2] = TT_OR;

    // Reset with the clock stopped.
    #2 rst_n = 1'b0;
    #1;
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    check_idle(2, "reset2");
    #5 rst_n = 1'b1;
    clk_en = 1'b1;
    repeat (3) step();

    sweep(0, TT_OR, 0, "or_ok");
    sweep(0, 4'b0000, 0, "stuck0");
    sweep(2, TT_OR, 0, "or_vs_and");
    sweep(0, TT_OR, 4, "start_while_busy");

    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = int'($urandom_range(2, 0));
      sweep(idx, 4'($urandom_range(15, 0)), 0, "random");
    end

    // start held: done every 4*(0+1)+2 cycles with pass set.
    gtt[1] = TT_OR;
    start_v[1] = 1'b1;
    step();
    ndone = 0; first = 0; prev = 0; bad = 0;
    for (k = 1; k <= 20; k++) begin
      if (done_v[1]) begin
        if (ndone == 0) first = k;
        else if (k - prev != 6) bad++;
        if (pass_v[1] !== 1'b1) bad++;
        prev = k;
        ndone++;
      end
      step();
    end
    start_v[1] = 1'b0;
    check("held_first_done", first, 5);
    check("held_done_count", ndone, 3);
    check("held_period_pass", bad, 0);
    repeat (10) step();
    check("held_idle", busy_v[1], 0);

    // Async reset during vector 2.
    gtt[0] = TT_OR;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    for (k = 1; k < 8; k++) step();
    check("mid_vec2", {a_v[0], b_v[0]}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check_idle(0, "mid_reset");
    repeat (2) step();
    rst_n = 1'b1;
    bad = 0;
    for (k = 0; k < 20; k++) begin
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
      step();
    end
    check("no_done_after_abort", bad, 0);
    sweep(0, TT_OR, 0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
